// File: rtl/string_case_engine.sv
// -----------------------------------------------------------------------------
// string_case_engine
//
// Streaming stage behind the string FIFO. Pops 32-bit words of four packed
// ASCII characters (char0 in [31:24]), applies a per-run case transform,
// and pushes the repacked word to an output valid/ready stream. A run ends
// on the first word containing a NUL byte or on word number MAX_WORDS.
//
// Optional feature macro: STR_VOWEL_COUNT_EN adds the vowel_count port and
// its counter. With the macro undefined the port and counter are absent.
//
// Parameters:
//   MAX_WORDS  words consumed per run before forced termination (>= 1)
//   CNT_W      width of char_count / vowel_count (must hold 4*MAX_WORDS)
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, mode[1:0]    run request (ignored while busy), case mode
//                       0 pass, 1 upper, 2 lower, 3 toggle
//   in_valid, in_data   FIFO not-empty flag and head word
//   in_ready            pop strobe
//   out_valid, out_data transformed word, held until out_ready
//   out_ready           downstream accept
//   busy                run in progress
//   done                one-cycle pulse at end of run
//   truncated           last run stopped on MAX_WORDS without a NUL
//   char_count          non-NUL characters of last/current run
//   vowel_count         vowels (pre-transform) of last/current run [opt]
// -----------------------------------------------------------------------------

// Per-character transform lane. i_dead says a NUL was seen in an earlier
// lane of the same word, so this byte is padding and is zeroed.
module string_case_lane (
  input  logic [1:0] i_mode,
  input  logic       i_dead,
  input  logic [7:0] i_char,
  output logic [7:0] o_char,
  output logic       o_live
`ifdef STR_VOWEL_COUNT_EN
  ,output logic      o_vowel
`endif
);
  logic w_is_lower, w_is_upper, w_to_upper, w_to_lower;

  assign w_is_lower = (i_char >= 8'h61) && (i_char <= 8'h7a);
  assign w_is_upper = (i_char >= 8'h41) && (i_char <= 8'h5a);
  assign w_to_upper = (i_mode == 2'd1) || (i_mode == 2'd3);
  assign w_to_lower = (i_mode == 2'd2) || (i_mode == 2'd3);
  assign o_live     = !i_dead && (i_char != 8'h00);

  always_comb begin
    o_char = i_char;
    if (!o_live)                      o_char = 8'h00;
    else if (w_to_upper && w_is_lower) o_char = i_char - 8'h20;
    else if (w_to_lower && w_is_upper) o_char = i_char + 8'h20;
  end

`ifdef STR_VOWEL_COUNT_EN
  // Fold to lower case (letters only) and match the five vowels.
  logic [7:0] w_fold;
  assign w_fold  = i_char | 8'h20;
  assign o_vowel = o_live && (w_is_lower || w_is_upper) &&
                   ((w_fold == 8'h61) || (w_fold == 8'h65) || (w_fold == 8'h69) ||
                    (w_fold == 8'h6f) || (w_fold == 8'h75));
`endif
endmodule

module string_case_engine #(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             truncated,
  output logic [CNT_W-1:0] char_count
`ifdef STR_VOWEL_COUNT_EN
  ,output logic [CNT_W-1:0] vowel_count
`endif
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int WC_W      = $clog2(MAX_WORDS + 1);
  localparam int LC_W      = $clog2(NUM_LANES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t                          r_state;
  logic [1:0]                      r_mode;
  logic [WC_W-1:0]                 r_words;
  logic                            r_out_valid;
  logic [31:0]                     r_out_data;
  logic                            r_done;
  logic                            r_trunc;
  logic [CNT_W-1:0]                r_char_cnt;

  logic [NUM_LANES-1:0][VEC_W-1:0] w_in_bytes;
  logic [NUM_LANES-1:0][VEC_W-1:0] w_out_bytes;
  logic [NUM_LANES:0]              w_dead;
  logic [NUM_LANES-1:0]            w_live;
  logic [31:0]                     w_out_word;
  logic [LC_W-1:0]                 w_nchar;
  logic                            w_has_nul;
  logic                            w_last_word;
  logic                            w_terminal;
  logic                            w_accept;
  logic                            w_xfer;

  // Lane i carries char i; char0 sits in the top byte of the word.
  always_comb begin
    w_dead = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_in_bytes[i] = in_data[VEC_W*(NUM_LANES-i)-1 -: VEC_W];
      w_dead[i+1]   = w_dead[i] | (w_in_bytes[i] == '0);
    end
  end

  always_comb begin
    w_out_word = '0;
    w_nchar    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_out_word[VEC_W*(NUM_LANES-i)-1 -: VEC_W] = w_out_bytes[i];
      w_nchar = w_nchar + LC_W'(w_live[i]);
    end
  end

`ifdef STR_VOWEL_COUNT_EN
  logic [NUM_LANES-1:0] w_vowel;
  logic [LC_W-1:0]      w_nvow;
  logic [CNT_W-1:0]     r_vowel_cnt;

  always_comb begin
    w_nvow = '0;
    for (int i = 0; i < NUM_LANES; i++) w_nvow = w_nvow + LC_W'(w_vowel[i]);
  end
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    string_case_lane u_lane (
      .i_mode (r_mode),
      .i_dead (w_dead[i]),
      .i_char (w_in_bytes[i]),
      .o_char (w_out_bytes[i]),
      .o_live (w_live[i])
`ifdef STR_VOWEL_COUNT_EN
      ,.o_vowel(w_vowel[i])
`endif
    );
  end

  assign w_has_nul   = w_dead[NUM_LANES];
  // r_words counts words already accepted, so the MAX_WORDS-th word is
  // the one arriving while the count equals MAX_WORDS-1.
  assign w_last_word = (r_words == WC_W'(MAX_WORDS - 1));
  assign w_terminal  = w_has_nul || w_last_word;
  assign w_xfer      = r_out_valid && out_ready;
  assign w_accept    = in_valid && in_ready;

  // Pop only in RUN and only when the output register will have room.
  assign in_ready    = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign busy        = (r_state != S_IDLE);
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign done        = r_done;
  assign truncated   = r_trunc;
  assign char_count  = r_char_cnt;
`ifdef STR_VOWEL_COUNT_EN
  assign vowel_count = r_vowel_cnt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'd0;
      r_words     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_trunc     <= 1'b0;
      r_char_cnt  <= '0;
`ifdef STR_VOWEL_COUNT_EN
      r_vowel_cnt <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      // A transfer empties the register; a same-cycle accept below refills it.
      if (w_xfer) r_out_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode     <= mode;
            r_words    <= '0;
            r_trunc    <= 1'b0;
            r_char_cnt <= '0;
`ifdef STR_VOWEL_COUNT_EN
            r_vowel_cnt <= '0;
`endif
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_word;
            r_words     <= r_words + WC_W'(1);
            r_char_cnt  <= r_char_cnt + CNT_W'(w_nchar);
`ifdef STR_VOWEL_COUNT_EN
            r_vowel_cnt <= r_vowel_cnt + CNT_W'(w_nvow);
`endif
            if (w_terminal) begin
              r_trunc <= !w_has_nul;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // done is registered here so it is high during FIN, one cycle
          // after the terminal word leaves the output register.
          if (w_xfer) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
